// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Wishbone classic master between an instruction read port and a data port.
// One transaction at a time, ties alternate, and accesses that get no ack or err end in an error completion.
module mem_port_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int timeout    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [addr_width-1:0]   i_req_addr,
    output logic                    i_resp_valid,
    output logic [data_width-1:0]   i_resp_data,
    output logic                    i_resp_err,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [addr_width-1:0]   d_req_addr,
    input  logic                    d_req_we,
    input  logic [data_width-1:0]   d_req_wdata,
    input  logic [data_width/8-1:0] d_req_sel,
    output logic                    d_resp_valid,
    output logic [data_width-1:0]   d_resp_data,
    output logic                    d_resp_err,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_dat_o,
    output logic [data_width/8-1:0] wb_sel,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    input  logic [data_width-1:0]   wb_dat_i
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]              state;
    logic [7:0]              timer;
    logic                    last_grant;
    logic                    gnt_d;
    logic [addr_width-1:0]   adr_q;
    logic                    we_q;
    logic [data_width-1:0]   wdata_q;
    logic [data_width/8-1:0] sel_q;
    logic                    pick_d;
    logic                    expire;
    logic                    done;
    logic                    fail;
    logic [data_width-1:0]   cap_data;

    // last_grant is 1 when data was served last, so a tie goes to whichever port waited
    always_comb begin
        pick_d       = d_req_valid && (!i_req_valid || !last_grant);
        i_req_ready  = !rst && state == IDLE && i_req_valid && !pick_d;
        d_req_ready  = !rst && state == IDLE && pick_d;
        expire       = timer == 8'(timeout - 1);
        done         = wb_ack || wb_err || expire;
        fail         = wb_err || !wb_ack;
        cap_data     = fail ? '0 : wb_dat_i;
        wb_cyc       = state == ACCESS;
        wb_stb       = state == ACCESS;
        wb_we        = we_q;
        wb_adr       = adr_q & {{(addr_width-2){1'b1}}, 2'b00};
        wb_dat_o     = wdata_q;
        wb_sel       = sel_q;
        i_resp_valid = state == RESP && !gnt_d;
        d_resp_valid = state == RESP && gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            last_grant  <= 1'b0;
            gnt_d       <= 1'b0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            sel_q       <= '0;
            i_resp_data <= '0;
            i_resp_err  <= 1'b0;
            d_resp_data <= '0;
            d_resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_req_ready || d_req_ready) begin
                    state      <= ACCESS;
                    timer      <= '0;
                    gnt_d      <= d_req_ready;
                    last_grant <= d_req_ready;
                    adr_q      <= d_req_ready ? d_req_addr : i_req_addr;
                    we_q       <= d_req_ready && d_req_we;
                    wdata_q    <= d_req_ready ? d_req_wdata : '0;
                    sel_q      <= d_req_ready ? d_req_sel : '1;
                end
                ACCESS: if (done) begin
                    // expiry without ack/err also lands here: fail is then 1 and data 0
                    state <= RESP;
                    if (gnt_d) begin
                        d_resp_data <= cap_data;
                        d_resp_err  <= fail;
                    end else begin
                        i_resp_data <= cap_data;
                        i_resp_err  <= fail;
                    end
                end else begin
                    timer <= timer + 8'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, reset corner cases and randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        i_req_valid = 0, i_req_ready, i_resp_valid, i_resp_err;
    logic [31:0] i_req_addr = 0, i_resp_data;
    logic        d_req_valid = 0, d_req_ready, d_req_we = 0, d_resp_valid, d_resp_err;
    logic [31:0] d_req_addr = 0, d_req_wdata = 0, d_resp_data;
    logic [3:0]  d_req_sel = 0, wb_sel;
    logic        wb_cyc, wb_stb, wb_we, wb_ack = 0, wb_err = 0;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i = 0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic iv, dv;
        logic [31:0] ia, da;
        logic we;
        logic [31:0] wd;
        logic [3:0] sel;
        int dly;   // stb cycle on which the slave answers; 0 = never
        int kind;  // 0 ack, 1 err, 2 ack+err
        logic [31:0] rd;
        logic exp_d;
        logic [31:0] exp_adr;
        logic exp_we;
        logic [3:0] exp_sel;
        logic [31:0] exp_dat, exp_rdata;
        logic exp_err;
        int exp_stb;
    } rec_t;

    rec_t tbl[12];

    mem_port_arbiter #(.addr_width(32), .data_width(32), .timeout(15)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_sel(d_req_sel),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic iv, dv, input logic [31:0] ia, da, input logic we,
                                input logic [31:0] wd, input logic [3:0] sel, input int dly, kind,
                                input logic [31:0] rd, input logic exp_d, input logic [31:0] exp_adr,
                                input logic exp_we, input logic [3:0] exp_sel,
                                input logic [31:0] exp_dat, exp_rdata, input logic exp_err, input int exp_stb);
        rec_t r;
        r.iv = iv; r.dv = dv; r.ia = ia; r.da = da; r.we = we; r.wd = wd; r.sel = sel;
        r.dly = dly; r.kind = kind; r.rd = rd; r.exp_d = exp_d; r.exp_adr = exp_adr;
        r.exp_we = exp_we; r.exp_sel = exp_sel; r.exp_dat = exp_dat; r.exp_rdata = exp_rdata;
        r.exp_err = exp_err; r.exp_stb = exp_stb;
        return r;
    endfunction

    task automatic txn(input rec_t r);
        int cnt = 0;
        int guard = 0;
        @(posedge clk); #1;
        i_req_valid = r.iv; d_req_valid = r.dv; i_req_addr = r.ia; d_req_addr = r.da;
        d_req_we = r.we; d_req_wdata = r.wd; d_req_sel = r.sel; wb_dat_i = r.rd;
        @(negedge clk);
        chk("ready_grant", {30'd0, i_req_ready, d_req_ready}, r.exp_d ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        i_req_valid = 0; d_req_valid = 0;
        @(negedge clk);
        while (wb_stb && guard < 300) begin
            cnt++;
            chk("wb_cyc", wb_cyc, 1);
            chk("wb_adr", wb_adr, r.exp_adr);
            chk("wb_we", wb_we, r.exp_we);
            chk("wb_sel", wb_sel, r.exp_sel);
            chk("wb_dat_o", wb_dat_o, r.exp_dat);
            chk("resp_idle", {i_resp_valid, d_resp_valid}, 0);
            if (cnt == r.dly) begin
                wb_ack = r.kind != 1;
                wb_err = r.kind != 0;
            end
            @(posedge clk); #1;
            wb_ack = 0; wb_err = 0;
            @(negedge clk);
            guard++;
        end
        chk("stb_cycles", cnt, r.exp_stb);
        chk("cyc_low", wb_cyc, 0);
        chk("i_resp_valid", i_resp_valid, !r.exp_d);
        chk("d_resp_valid", d_resp_valid, r.exp_d);
        chk("resp_data", r.exp_d ? d_resp_data : i_resp_data, r.exp_rdata);
        chk("resp_err", r.exp_d ? d_resp_err : i_resp_err, r.exp_err);
        @(negedge clk);
        chk("resp_pulse", {i_resp_valid, d_resp_valid}, 0);
        chk("resp_hold", r.exp_d ? d_resp_data : i_resp_data, r.exp_rdata);
    endtask

    initial begin
        logic last_was_d;
        rec_t r;
        tbl[0]  = mk(1, 1, 32'h200, 32'h300, 0, 0, 4'hF, 1, 0, 32'h11, 1, 32'h300, 0, 4'hF, 0, 32'h11, 0, 1);
        tbl[1]  = mk(1, 1, 32'h200, 32'h304, 0, 0, 4'hF, 3, 0, 32'h22, 0, 32'h200, 0, 4'hF, 0, 32'h22, 0, 3);
        tbl[2]  = mk(1, 1, 32'h204, 32'h304, 0, 0, 4'hF, 2, 0, 32'h33, 1, 32'h304, 0, 4'hF, 0, 32'h33, 0, 2);
        tbl[3]  = mk(1, 1, 32'h204, 32'h308, 0, 0, 4'hF, 1, 0, 32'h44, 0, 32'h204, 0, 4'hF, 0, 32'h44, 0, 1);
        tbl[4]  = mk(1, 0, 32'h100, 0, 0, 0, 0, 2, 0, 32'h13, 0, 32'h100, 0, 4'hF, 0, 32'h13, 0, 2);
        tbl[5]  = mk(0, 1, 0, 32'h1003, 1, 32'hAB000000, 4'b1000, 1, 0, 32'h5A5A5A5A,
                     1, 32'h1000, 1, 4'b1000, 32'hAB000000, 32'h5A5A5A5A, 0, 1);
        tbl[6]  = mk(0, 1, 0, 32'h2000, 0, 0, 4'hF, 0, 0, 32'hFFFFFFFF, 1, 32'h2000, 0, 4'hF, 0, 0, 1, 15);
        tbl[7]  = mk(0, 1, 0, 32'h3000, 0, 0, 4'hF, 2, 1, 32'h12345678, 1, 32'h3000, 0, 4'hF, 0, 0, 1, 2);
        tbl[8]  = mk(1, 0, 32'h104, 0, 0, 0, 0, 1, 0, 32'h99, 0, 32'h104, 0, 4'hF, 0, 32'h99, 0, 1);
        tbl[9]  = mk(0, 1, 0, 32'h3004, 1, 32'h11223344, 4'h3, 1, 2, 32'h77,
                     1, 32'h3004, 1, 4'h3, 32'h11223344, 0, 1, 1);
        tbl[10] = mk(0, 1, 0, 32'h3008, 0, 0, 4'hF, 15, 0, 32'hCAFEF00D,
                     1, 32'h3008, 0, 4'hF, 0, 32'hCAFEF00D, 0, 15);
        tbl[11] = mk(1, 1, 32'h10B, 32'h400, 0, 0, 4'hF, 4, 0, 32'h55, 0, 32'h108, 0, 4'hF, 0, 32'h55, 0, 4);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_outputs", {wb_cyc, wb_stb, wb_we, i_resp_valid, d_resp_valid, i_resp_err, d_resp_err,
                            i_req_ready, d_req_ready}, 0);
        chk("rst_wb_adr", wb_adr, 0);
        chk("rst_wb_sel", wb_sel, 0);
        chk("rst_resp_data", i_resp_data | d_resp_data, 0);

        for (int i = 0; i < 12; i++) txn(tbl[i]);

        // reset in the middle of an access, followed by a stale ack
        @(posedge clk); #1;
        d_req_valid = 1; d_req_addr = 32'h500; d_req_we = 0; d_req_sel = 4'hF; wb_dat_i = 32'h66;
        @(posedge clk); #1;
        d_req_valid = 0;
        @(negedge clk);
        chk("mid_stb", wb_stb, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0; wb_ack = 1;
        @(negedge clk);
        chk("rst_mid_cyc", {wb_cyc, wb_stb}, 0);
        chk("rst_mid_resp", {i_resp_valid, d_resp_valid}, 0);
        chk("rst_mid_adr", wb_adr, 0);
        @(posedge clk); #1 wb_ack = 0;
        @(negedge clk);
        chk("stale_ack_cyc", wb_cyc, 0);
        chk("stale_ack_resp", {i_resp_valid, d_resp_valid}, 0);
        chk("stale_ack_data", d_resp_data, 0);

        txn(mk(1, 1, 32'h600, 32'h700, 0, 0, 4'hF, 1, 0, 32'h88, 1, 32'h700, 0, 4'hF, 0, 32'h88, 0, 1));
        last_was_d = 1;

        for (int k = 0; k < 40; k++) begin
            bit timed_out;
            r.iv = 1'($urandom); r.dv = 1'($urandom);
            if (!r.iv && !r.dv) r.iv = 1;
            r.ia = $urandom; r.da = $urandom; r.we = 1'($urandom); r.wd = $urandom;
            r.sel = 4'($urandom); r.dly = $urandom_range(0, 17); r.kind = $urandom_range(0, 2);
            r.rd = $urandom;
            r.exp_d = (r.iv && r.dv) ? !last_was_d : r.dv;
            last_was_d = r.exp_d;
            timed_out = r.dly == 0 || r.dly > 15;
            r.exp_stb = timed_out ? 15 : r.dly;
            r.exp_err = timed_out || r.kind != 0;
            r.exp_rdata = r.exp_err ? 32'd0 : r.rd;
            r.exp_adr = (r.exp_d ? r.da : r.ia) & ~32'h3;
            r.exp_we = r.exp_d && r.we;
            r.exp_sel = r.exp_d ? r.sel : 4'hF;
            r.exp_dat = r.exp_d ? r.wd : 32'd0;
            txn(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): addr_width, 32, address width.
REQ-002 data_width, 32, data width; byte-select width = data_width/8.
REQ-003 timeout, 255, maximum bus cycles in ACCESS before error completion; legal range 1..255.
REQ-004 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock; all logic on its rising edge.
REQ-005 rst, in, 1, reset; synchronous, active-high.
REQ-006 i_req_valid, in, 1, instruction read request.
REQ-007 i_req_ready, out, 1, instruction request accepted this cycle.
REQ-008 i_req_addr, in, addr_width, instruction address.
REQ-009 i_resp_valid, out, 1, instruction response strobe, one cycle.
REQ-010 i_resp_data, out, data_width, instruction read data.
REQ-011 i_resp_err, out, 1, instruction access failed.
REQ-012 d_req_valid, in, 1, data request.
REQ-013 d_req_ready, out, 1, data request accepted this cycle.
REQ-014 d_req_addr / d_req_we / d_req_wdata / d_req_sel, in, addr_width / 1 / data_width / data_width/8, data address, write enable, write data, byte strobes.
REQ-015 d_resp_valid / d_resp_data / d_resp_err, out, 1 / data_width / 1, data response strobe, read data, error.
REQ-016 wb_cyc / wb_stb / wb_we, out, 1 each, Wishbone classic master cycle, strobe, write enable.
REQ-017 wb_adr / wb_dat_o / wb_sel, out, addr_width / data_width / data_width/8, bus address, write data, byte selects.
REQ-018 wb_ack / wb_err, in, 1 each, slave acknowledge, slave error.
REQ-019 wb_dat_i, in, data_width, slave read data.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-021 IDLE: grant a single requester and assert only its req_ready combinationally; transfer = valid && ready; the other ready stays 0.
REQ-022 Tie (both valid): grant the requester not served last (last_grant register); single valid: grant it regardless.
REQ-023 On transfer: latch address, we, wdata and sel, record grant, update last_grant, go to ACCESS next cycle.
REQ-024 Instruction transactions SHALL drive wb_we=0, wb_sel=all ones, wb_dat_o=0.
REQ-025 wb_adr SHALL be the latched address with bits [1:0] forced to 0.
REQ-026 ACCESS: wb_cyc=wb_stb=1 with all wb outputs from latched registers, stable for the whole access.
REQ-027 ACCESS, wb_ack or wb_err high: capture wb_dat_i (0 if wb_err), err=wb_err, go to RESP; wb_cyc/wb_stb low next cycle.
REQ-028 ACCESS timer counts cycles in ACCESS; if it reaches timeout with no ack/err, go to RESP with err=1, data=0; wb_stb is high exactly timeout cycles.
REQ-029 ack/err in the same cycle as expiry: ack/err wins; wb_ack and wb_err both high: err=1.
REQ-030 RESP: pulse granted port's resp_valid for exactly one cycle with captured data/err, then IDLE; no response back-pressure.
REQ-031 wb_ack/wb_err outside ACCESS SHALL be ignored.
REQ-032 Latency: accept cycle N, wb_stb high from N+1, ack at cycle M, resp_valid at M+1, earliest next accept M+2.
REQ-033 resp_data/resp_err of a port hold their last value when resp_valid=0.

Reset
REQ-034 rst high at a clock edge: state=IDLE, timer=0, last_grant=instruction (data wins the first tie), all outputs 0 the next cycle, including mid-ACCESS or RESP; the aborted transaction produces no response.

Verification
REQ-035 Instruction read 0x100, wb_ack after 2 stb cycles, wb_dat_i=0x00000013 -> wb_we=0, wb_sel=4'hF, i_resp_valid for 1 cycle with 0x13, err=0.
REQ-036 Both requests valid continuously from reset -> grants D,I,D,I over 4 transactions; never both ready high.
REQ-037 Data store addr 0x1003, sel=4'b1000, wdata=0xAB000000 -> wb_adr=0x1000, wb_we=1, wb_sel=4'b1000, d_resp_valid with err=0.
REQ-038 timeout=15, no ack -> wb_stb high 15 cycles, then d_resp_valid with err=1, data=0.
REQ-039 wb_err on a data load -> d_resp_err=1, d_resp_data=0; the next instruction request is served normally.
REQ-040 rst during ACCESS -> wb_cyc=0 next cycle, no resp_valid; a stale wb_ack after reset is ignored.
